id_issue_ctrl: RTL

Registered issue stage for the MIPS pipeline, placed between the instruction decoder and the ID/EX boundary. It holds decoded instructions behind a valid/ready handshake. A per-register latency scoreboard stalls any instruction whose source register is still produced by a multi-cycle operation (load, multiply). It replaces the fixed no-stall behaviour of the current decode stage with real load-use and long-latency interlocks.

---
 rtl/id_issue_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/id_issue_ctrl.sv
// ---------------------------------------------------------------------------
// id_issue_ctrl
//
// Registered issue stage between the instruction decoder and the ID/EX
// boundary. Decoded instructions are taken over a valid/ready handshake and
// held in a single output register for EX. A per-register latency scoreboard
// blocks any instruction whose source is still being produced by a
// multi-cycle operation (load, multiply), giving load-use and long-latency
// interlocks.
//
// Parameters
//   PAYLOAD_W   width of the opaque decoded bundle carried to EX
//   REG_ADDR_W  register address width (scoreboard has 2**REG_ADDR_W entries)
//   LAT_W       width of the result-latency field
//
// Ports
//   clk, rst       clock (rising edge), synchronous active-high reset
//   flush          drop the presented instruction and the held output
//   in_valid       decoder presents an instruction
//   in_ready       instruction accepted (or dropped by flush) this cycle
//   in_payload     decoded bundle
//   in_rs_re/addr  first source read enable / register
//   in_rt_re/addr  second source read enable / register
//   in_we/in_wd    destination write enable / register
//   in_lat         bubbles a dependant must wait (ALU 0, load 1, mul 3)
//   out_valid      EX-bound instruction held
//   out_ready      EX accepts; also the pipeline-advance strobe
//   out_payload    held bundle
//   out_we/out_wd  held write enable / destination
//   stallreq       decode blocked by a hazard
// ---------------------------------------------------------------------------
module id_issue_ctrl #(
   parameter int PAYLOAD_W  = 64,
   parameter int REG_ADDR_W = 5,
   parameter int LAT_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PAYLOAD_W-1:0]  in_payload,
   input  logic                  in_rs_re,
   input  logic                  in_rt_re,
   input  logic [REG_ADDR_W-1:0] in_rs_addr,
   input  logic [REG_ADDR_W-1:0] in_rt_addr,
   input  logic                  in_we,
   input  logic [REG_ADDR_W-1:0] in_wd,
   input  logic [LAT_W-1:0]      in_lat,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PAYLOAD_W-1:0]  out_payload,
   output logic                  out_we,
   output logic [REG_ADDR_W-1:0] out_wd,
   output logic                  stallreq
);

   localparam int NREG = 1 << REG_ADDR_W;

   // Remaining bubbles before each register's result may be consumed.
   logic [LAT_W-1:0] cnt     [NREG];
   logic [LAT_W-1:0] cnt_nxt [NREG];

   logic busy_rs;
   logic busy_rt;
   logic hazard;
   logic slot_free;
   logic issue;

   // Entry 0 is held at zero, so r0 as a source can never look busy.
   // Reads use the pre-update counters, so an instruction never stalls on
   // its own destination.
   assign busy_rs   = (cnt[in_rs_addr] != '0);
   assign busy_rt   = (cnt[in_rt_addr] != '0);
   assign hazard    = in_valid & ((in_rs_re & busy_rs) | (in_rt_re & busy_rt));
   assign slot_free = ~out_valid | out_ready;
   assign issue     = in_valid & ~hazard & ~flush & slot_free;

   // Under flush the presented instruction is consumed and discarded.
   assign in_ready  = flush | (~hazard & slot_free);
   assign stallreq  = hazard & ~flush;

   // Scoreboard next state. Counters only tick down on advancing cycles so
   // the bubble count stretches with downstream stalls; flush leaves them
   // alone because already-issued producers still write back.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         logic [LAT_W-1:0] dec;
         // NOTE: every always_comb output gets a value on every path first;
         // a missed branch would otherwise infer a latch.
         cnt_nxt[r] = '0;
         dec        = ((cnt[r] != '0) && out_ready) ? cnt[r] - 1'b1 : cnt[r];
         if (r != 0) begin
            if (issue && in_we && (in_wd == REG_ADDR_W'(r))) begin
               // WAW: keep whichever producer finishes later.
               cnt_nxt[r] = (in_lat > dec) ? in_lat : dec;
            end else begin
               cnt_nxt[r] = dec;
            end
         end
      end
   end

   // NOTE: the scoreboard is a handful of flops, not a RAM, so it takes a
   // reset; a mid-stall reset must release every interlock at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      end
   end

   // Output register: flush beats issue, issue beats drain. A new issue with
   // out_ready high replaces the departing instruction in the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_payload <= '0;
         out_we      <= 1'b0;
         out_wd      <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (issue) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // Payload fields only move on issue; they are don't-care otherwise.
         if (issue) begin
            out_payload <= in_payload;
            out_we      <= in_we;
            out_wd      <= in_wd;
         end
      end
   end

endmodule
